// File: rtl/bp8051_pkg.sv
// rtl/bp8051_pkg.sv - shared PC width, branch entry layout and queue depth default
// Contents: PC_W, DEPTH_DEF, pc_t, entry_t, redirect_target()
package bp8051_pkg;

  localparam int PC_W      = 16;
  localparam int DEPTH_DEF = 4;

  typedef logic [PC_W-1:0] pc_t;

  // One in-flight conditional branch as captured at issue time.
  typedef struct packed {
    pc_t  pc;
    logic pred;
    pc_t  target;
    pc_t  fall;
  } entry_t;

  // Corrected fetch PC once the real outcome is known.
  function automatic pc_t redirect_target(input entry_t e, input logic taken);
    return taken ? e.target : e.fall;
  endfunction

endpackage

// File: rtl/branch_resolve_8051_if.sv
// rtl/branch_resolve_8051_if.sv - issue/resolve/predictor-update/redirect bus
// master: fetch/execute side (drives iss_*, res_*), slave: branch_resolve_8051
interface branch_resolve_8051_if;
  import bp8051_pkg::*;

  logic iss_valid;
  logic iss_ready;
  pc_t  iss_pc;
  logic iss_pred;
  pc_t  iss_target;
  pc_t  iss_fall;
  logic res_valid;
  logic res_taken;
  logic bp_branch;
  logic bp_actual;
  pc_t  bp_pc;
  logic redirect;
  pc_t  redirect_pc;

  modport master (
    output iss_valid, iss_pc, iss_pred, iss_target, iss_fall, res_valid, res_taken,
    input  iss_ready, bp_branch, bp_actual, bp_pc, redirect, redirect_pc
  );

  modport slave (
    input  iss_valid, iss_pc, iss_pred, iss_target, iss_fall, res_valid, res_taken,
    output iss_ready, bp_branch, bp_actual, bp_pc, redirect, redirect_pc
  );

endinterface

// File: rtl/bq_fifo_8051.sv
// rtl/bq_fifo_8051.sv - in-order FIFO of in-flight branch entries
// Ports: clk, rst (sync, active-high), push/push_data, pop, clear (flush all),
//        count (0..DEPTH), head (oldest entry, valid when count > 0)
module bq_fifo_8051
  import bp8051_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  entry_t              push_data,
  input  logic                pop,
  input  logic                clear,
  output logic [CNT_BITS-1:0] count,
  output entry_t              head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/branch_resolve_8051.sv
// rtl/branch_resolve_8051.sv - conditional branch tracking, resolution and redirect
// Ports: clk, rst (sync, active-high), br (slave bus: issue, resolve, predictor
//        update, redirect), branch_cnt, mispredict_cnt, err_underflow (sticky)
module branch_resolve_8051
  import bp8051_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_8051_if.slave br,
  output logic [CNT_W-1:0]     branch_cnt,
  output logic [CNT_W-1:0]     mispredict_cnt,
  output logic                 err_underflow
);

  localparam int                  CNT_BITS = $clog2(DEPTH + 1);
  localparam logic [CNT_BITS-1:0] FULL     = CNT_BITS'(DEPTH);

  logic [CNT_BITS-1:0] count;
  entry_t              head;
  entry_t              push_data;
  logic                pop, push, mispredict;

  logic             bp_branch_q, bp_branch_d;
  logic             bp_actual_q, bp_actual_d;
  pc_t              bp_pc_q, bp_pc_d;
  logic             redirect_q, redirect_d;
  pc_t              redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
  logic             err_underflow_q, err_underflow_d;

  assign push_data = '{pc: br.iss_pc, pred: br.iss_pred, target: br.iss_target, fall: br.iss_fall};

  // count is registered, so iss_ready has no combinational path from inputs.
  assign br.iss_ready = (count < FULL);
  assign pop          = br.res_valid && (count != '0);
  assign mispredict   = pop && (br.res_taken != head.pred);
  // A mispredict flushes the queue; anything issued alongside it is wrong-path.
  assign push         = br.iss_valid && br.iss_ready && !mispredict;

  bq_fifo_8051 #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (mispredict),
    .count     (count),
    .head      (head)
  );

  always_comb begin
    bp_branch_d      = pop;
    bp_actual_d      = pop && br.res_taken;
    bp_pc_d          = pop ? head.pc : '0;
    redirect_d       = mispredict;
    redirect_pc_d    = mispredict ? redirect_target(head, br.res_taken) : '0;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (pop && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (mispredict && !(&mispredict_cnt_q)) begin
      mispredict_cnt_d = mispredict_cnt_q + 1'b1;
    end
    err_underflow_d = err_underflow_q || (br.res_valid && (count == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_branch_q      <= 1'b0;
      bp_actual_q      <= 1'b0;
      bp_pc_q          <= '0;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      err_underflow_q  <= 1'b0;
    end else begin
      bp_branch_q      <= bp_branch_d;
      bp_actual_q      <= bp_actual_d;
      bp_pc_q          <= bp_pc_d;
      redirect_q       <= redirect_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      err_underflow_q  <= err_underflow_d;
    end
  end

  assign br.bp_branch    = bp_branch_q;
  assign br.bp_actual    = bp_actual_q;
  assign br.bp_pc        = bp_pc_q;
  assign br.redirect     = redirect_q;
  assign br.redirect_pc  = redirect_pc_q;
  assign branch_cnt      = branch_cnt_q;
  assign mispredict_cnt  = mispredict_cnt_q;
  assign err_underflow   = err_underflow_q;

endmodule

// File: tb/tb_branch_resolve_8051.sv
// tb/tb_branch_resolve_8051.sv - directed self-checking bench for branch_resolve_8051
module tb_branch_resolve_8051;
  import bp8051_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;
  logic        err_underflow;
  int          n_checks = 0;
  int          n_err    = 0;

  branch_resolve_8051_if bus ();

  branch_resolve_8051 #(.DEPTH(4), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .br             (bus.slave),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_taken = 1'b0;
  endtask

  task automatic set_issue(input logic [15:0] pc, input logic pred,
                           input logic [15:0] tgt, input logic [15:0] fall);
    bus.iss_valid  = 1'b1;
    bus.iss_pc     = pc;
    bus.iss_pred   = pred;
    bus.iss_target = tgt;
    bus.iss_fall   = fall;
  endtask

  task automatic resolve(input logic taken);
    bus.res_valid = 1'b1;
    bus.res_taken = taken;
  endtask

  initial begin
    idle();
    set_issue(16'h0, 1'b0, 16'h0, 16'h0);
    bus.iss_valid = 1'b0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_bp_branch", {31'b0, bus.bp_branch}, 32'd0);
    check("rst_redirect", {31'b0, bus.redirect}, 32'd0);
    check("rst_branch_cnt", {16'b0, branch_cnt}, 32'd0);
    check("rst_mispredict_cnt", {16'b0, mispredict_cnt}, 32'd0);
    check("rst_err", {31'b0, err_underflow}, 32'd0);
    check("rst_iss_ready", {31'b0, bus.iss_ready}, 32'd1);
    rst = 1'b0;

    // Correct prediction
    set_issue(16'h0100, 1'b1, 16'h0120, 16'h0102);
    step();
    idle();
    resolve(1'b1);
    step();
    idle();
    check("ok_bp_branch", {31'b0, bus.bp_branch}, 32'd1);
    check("ok_bp_actual", {31'b0, bus.bp_actual}, 32'd1);
    check("ok_bp_pc", {16'b0, bus.bp_pc}, 32'h0100);
    check("ok_redirect", {31'b0, bus.redirect}, 32'd0);
    check("ok_branch_cnt", {16'b0, branch_cnt}, 32'd1);
    step();
    check("ok_bp_branch_drop", {31'b0, bus.bp_branch}, 32'd0);

    // Mispredict, fall-through correction
    set_issue(16'h0100, 1'b1, 16'h0120, 16'h0102);
    step();
    idle();
    resolve(1'b0);
    step();
    idle();
    check("mp_redirect", {31'b0, bus.redirect}, 32'd1);
    check("mp_redirect_pc", {16'b0, bus.redirect_pc}, 32'h0102);
    check("mp_mispredict_cnt", {16'b0, mispredict_cnt}, 32'd1);
    check("mp_bp_actual", {31'b0, bus.bp_actual}, 32'd0);
    check("mp_branch_cnt", {16'b0, branch_cnt}, 32'd2);
    step();
    check("mp_redirect_one_cycle", {31'b0, bus.redirect}, 32'd0);

    // Fill to DEPTH, reject a 5th, then pop with concurrent push and wrap
    for (int i = 0; i < 4; i++) begin
      set_issue(16'h0200 + 16'(i * 4), 1'b1, 16'h0280, 16'h0202 + 16'(i * 4));
      step();
    end
    check("full_iss_ready", {31'b0, bus.iss_ready}, 32'd0);
    set_issue(16'h0300, 1'b1, 16'h0380, 16'h0302);
    step();
    check("full_still_not_ready", {31'b0, bus.iss_ready}, 32'd0);
    idle();
    resolve(1'b1);
    step();
    check("full_pop_bp_pc", {16'b0, bus.bp_pc}, 32'h0200);
    check("full_pop_iss_ready", {31'b0, bus.iss_ready}, 32'd1);
    set_issue(16'h0210, 1'b1, 16'h0280, 16'h0212);
    resolve(1'b1);
    step();
    idle();
    check("pushpop_bp_pc", {16'b0, bus.bp_pc}, 32'h0204);
    check("pushpop_iss_ready", {31'b0, bus.iss_ready}, 32'd1);
    resolve(1'b1);
    step();
    check("order_bp_pc_0208", {16'b0, bus.bp_pc}, 32'h0208);
    step();
    check("order_bp_pc_020c", {16'b0, bus.bp_pc}, 32'h020C);
    step();
    check("wrap_bp_pc_0210", {16'b0, bus.bp_pc}, 32'h0210);
    check("wrap_branch_cnt", {16'b0, branch_cnt}, 32'd7);
    check("wrap_no_redirect", {31'b0, bus.redirect}, 32'd0);

    // Underflow: queue empty now, the 5th issue must not be present
    step();
    idle();
    check("uf_bp_branch", {31'b0, bus.bp_branch}, 32'd0);
    check("uf_redirect", {31'b0, bus.redirect}, 32'd0);
    check("uf_err", {31'b0, err_underflow}, 32'd1);
    check("uf_branch_cnt", {16'b0, branch_cnt}, 32'd7);
    step();
    check("uf_err_sticky", {31'b0, err_underflow}, 32'd1);

    // Mispredict with three queued and a same-cycle issue
    for (int i = 0; i < 3; i++) begin
      set_issue(16'h0400 + 16'(i * 4), 1'b0, 16'h0500, 16'h0402 + 16'(i * 4));
      step();
    end
    set_issue(16'h0600, 1'b1, 16'h0680, 16'h0602);
    resolve(1'b1);
    step();
    idle();
    check("flush_redirect", {31'b0, bus.redirect}, 32'd1);
    check("flush_redirect_pc", {16'b0, bus.redirect_pc}, 32'h0500);
    check("flush_bp_pc", {16'b0, bus.bp_pc}, 32'h0400);
    check("flush_mispredict_cnt", {16'b0, mispredict_cnt}, 32'd2);
    check("flush_branch_cnt", {16'b0, branch_cnt}, 32'd8);
    resolve(1'b1);
    step();
    idle();
    check("flush_single_pulse", {31'b0, bus.redirect}, 32'd0);
    check("flush_queue_empty", {31'b0, bus.bp_branch}, 32'd0);

    // Reset with entries in flight
    for (int i = 0; i < 3; i++) begin
      set_issue(16'h0700 + 16'(i * 4), 1'b1, 16'h0780, 16'h0702 + 16'(i * 4));
      step();
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_bp_branch", {31'b0, bus.bp_branch}, 32'd0);
    check("rst2_redirect", {31'b0, bus.redirect}, 32'd0);
    check("rst2_branch_cnt", {16'b0, branch_cnt}, 32'd0);
    check("rst2_mispredict_cnt", {16'b0, mispredict_cnt}, 32'd0);
    check("rst2_err", {31'b0, err_underflow}, 32'd0);
    check("rst2_iss_ready", {31'b0, bus.iss_ready}, 32'd1);
    resolve(1'b1);
    step();
    idle();
    check("rst2_discarded", {31'b0, bus.bp_branch}, 32'd0);
    check("rst2_err_after", {31'b0, err_underflow}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
